// File: rtl/fetch_unit.sv
// SISC instruction fetch stage: program counter, instruction register and imem req/ack FSM.
// Define FETCH_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module fetch_unit #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_req,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc,
  output logic          fetch_busy,
  output logic          fetch_done
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] ir_q, ir_d;

`ifdef FETCH_PREFETCH_EN
  logic [DW-1:0] pbuf_q, pbuf_d;
  logic [AW-1:0] pbuf_addr_q, pbuf_addr_d;
  logic          pbuf_valid_q, pbuf_valid_d;
  logic          pf_pend_q, pf_pend_d;
  logic          pf_drop_q, pf_drop_d;
  logic          fwait_q, fwait_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic          start;
  logic [AW-1:0] start_pc;
`endif

  assign ir         = ir_q;
  assign opcode     = ir_q[31:28];
  assign mm         = ir_q[27:24];
  assign imm        = ir_q[15:0];
  assign pc         = pc_q;
  assign imem_addr  = addr_q;
  assign fetch_busy = (state_q == REQ);
  assign fetch_done = (state_q == DONE);
`ifdef FETCH_PREFETCH_EN
  assign imem_req   = (state_q == REQ) || pf_pend_q;
`else
  assign imem_req   = (state_q == REQ);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (pc_rst) begin
      pc_d = '0;
    end else if (pc_write) begin
      if (!pc_sel)     pc_d = pc_q + AW'(1);
      else if (br_sel) pc_d = AW'(imm);
      else             pc_d = pc_q + AW'($signed(imm));
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
`ifdef FETCH_PREFETCH_EN
    pbuf_d       = pbuf_q;
    pbuf_addr_d  = pbuf_addr_q;
    pbuf_valid_d = pbuf_valid_q;
    pf_pend_d    = pf_pend_q;
    pf_drop_d    = pf_drop_q;
    fwait_d      = fwait_q;
    fpc_d        = fpc_q;
    start        = 1'b0;
    start_pc     = pc_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef FETCH_PREFETCH_EN
        // A fetch arriving while a prefetch is in flight is parked with its PC until the ack.
        if (fwait_q) begin
          start    = !pf_pend_q;
          start_pc = fpc_q;
        end else if (fetch_req && pf_pend_q) begin
          fwait_d = 1'b1;
          fpc_d   = pc_q;
        end else begin
          start = fetch_req;
        end
        if (start) begin
          fwait_d      = 1'b0;
          pbuf_valid_d = 1'b0;
          addr_d       = start_pc;
          if (pbuf_valid_q && (pbuf_addr_q == start_pc)) begin
            ir_d    = pbuf_q;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
`else
        if (fetch_req) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
`endif
      end
      REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef FETCH_PREFETCH_EN
        addr_d    = addr_q + AW'(1);
        pf_pend_d = 1'b1;
        pf_drop_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef FETCH_PREFETCH_EN
    if (pf_pend_q && imem_ack) begin
      pf_pend_d = 1'b0;
      if (!pf_drop_q) begin
        pbuf_d       = imem_rdata;
        pbuf_addr_d  = addr_q;
        pbuf_valid_d = 1'b1;
      end
    end
    // A PC clear cannot abort a prefetch already on the bus, so its data is discarded on arrival.
    if (pc_rst) begin
      pbuf_valid_d = 1'b0;
      pf_drop_d    = pf_pend_d;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
    end
  end

`ifdef FETCH_PREFETCH_EN
  // NOTE: the buffer word is reset along with its tag so simulation never carries X into ir.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pbuf_q       <= '0;
      pbuf_addr_q  <= '0;
      pbuf_valid_q <= 1'b0;
      pf_pend_q    <= 1'b0;
      pf_drop_q    <= 1'b0;
      fwait_q      <= 1'b0;
      fpc_q        <= '0;
    end else begin
      pbuf_q       <= pbuf_d;
      pbuf_addr_q  <= pbuf_addr_d;
      pbuf_valid_q <= pbuf_valid_d;
      pf_pend_q    <= pf_pend_d;
      pf_drop_q    <= pf_drop_d;
      fwait_q      <= fwait_d;
      fpc_q        <= fpc_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: PC update table plus handshake corner sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        fetch_req;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        fetch_busy;
  logic        fetch_done;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.AW(16), .DW(32)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .fetch_req  (fetch_req),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .imm        (imm),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  exp_op;
    logic [3:0]  exp_mm;
    logic [15:0] exp_imm;
    logic        rst;
    logic        wr;
    logic        sel;
    logic        bsel;
    logic [15:0] exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Demand fetch: request, optional wait cycles (optionally bumping the PC), ack, done pulse.
  task automatic do_fetch(input logic [31:0] word, input int delay, input logic [15:0] exp_addr,
                          input bit bump);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("req_up", imem_req, 1);
    check("busy_up", fetch_busy, 1);
    check("req_addr", imem_addr, exp_addr);
    check("done_early", fetch_done, 0);
    for (int i = 0; i < delay; i++) begin
      if (bump && i == 0) begin
        pc_write = 1'b1;
        pc_sel   = 1'b0;
      end
      step();
      pc_write = 1'b0;
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, exp_addr);
      check("done_wait", fetch_done, 0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("done_pulse", fetch_done, 1);
    check("busy_drop", fetch_busy, 0);
    check("ir_load", ir, word);
    step();
    check("done_once", fetch_done, 0);
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic pf_ack(input logic [15:0] exp_addr, input logic [31:0] word);
    check("pf_req", imem_req, 1);
    check("pf_addr", imem_addr, exp_addr);
    check("pf_busy", fetch_busy, 0);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("pf_req_drop", imem_req, 0);
  endtask
`endif

  initial begin
`ifndef FETCH_PREFETCH_EN
    vec_t        vecs [11];
    logic [15:0] cur_pc;
`endif
    rst_f      = 1'b0;
    fetch_req  = 1'b1;
    pc_rst     = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    br_sel     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    // Reset state, with a fetch request held during reset.
    #12;
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_done", fetch_done, 0);
    step();
    fetch_req = 1'b0;
    rst_f     = 1'b1;
    step();
    check("post_rst_req", imem_req, 0);

`ifndef FETCH_PREFETCH_EN
    vecs[0]  = '{32'h0000_0002, 4'h0, 4'h0, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002};
    vecs[1]  = '{32'h1200_FFFD, 4'h1, 4'h2, 16'hFFFD, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF};
    vecs[2]  = '{32'h2300_0000, 4'h2, 4'h3, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{32'h3400_0040, 4'h3, 4'h4, 16'h0040, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040};
    vecs[4]  = '{32'h4500_0010, 4'h4, 4'h5, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0050};
    vecs[5]  = '{32'h5600_FFF0, 4'h5, 4'h6, 16'hFFF0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040};
    vecs[6]  = '{32'h6700_1234, 4'h6, 4'h7, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040};
    vecs[7]  = '{32'h7800_8000, 4'h7, 4'h8, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[8]  = '{32'h9A00_FFFF, 4'h9, 4'hA, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF};
    vecs[9]  = '{32'hAB00_0000, 4'hA, 4'hB, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[10] = '{32'hCD00_0010, 4'hC, 4'hD, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0010};

    cur_pc = 16'h0000;
    for (int v = 0; v < 11; v++) begin
      do_fetch(vecs[v].word, 0, cur_pc, 1'b0);
      check($sformatf("v%0d_opcode", v), opcode, vecs[v].exp_op);
      check($sformatf("v%0d_mm", v), mm, vecs[v].exp_mm);
      check($sformatf("v%0d_imm", v), imm, vecs[v].exp_imm);
      pc_rst   = vecs[v].rst;
      pc_write = vecs[v].wr;
      pc_sel   = vecs[v].sel;
      br_sel   = vecs[v].bsel;
      step();
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      check($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
      cur_pc = vecs[v].exp_pc;
    end

    // Immediate ack at pc 0x0010, then the same fetch with a 3-cycle ack delay and a PC bump.
    do_fetch(32'h8123_0005, 0, 16'h0010, 1'b0);
    check("a_opcode", opcode, 4'h8);
    check("a_mm", mm, 4'h1);
    check("a_imm", imm, 16'h0005);
    do_fetch(32'h8123_0005, 3, 16'h0010, 1'b1);
    check("b_pc_bumped", pc, 16'h0011);

    // fetch_req and pc_write in the same IDLE cycle: fetch uses the old PC.
    fetch_req = 1'b1;
    pc_write  = 1'b1;
    step();
    fetch_req = 1'b0;
    pc_write  = 1'b0;
    check("d_addr_old_pc", imem_addr, 16'h0011);
    check("d_pc_new", pc, 16'h0012);
    imem_ack   = 1'b1;
    imem_rdata = 32'hE000_0001;
    step();
    imem_ack   = 1'b0;
    check("d_done", fetch_done, 1);
    step();

    // fetch_req held into REQ and pulsed in DONE is ignored.
    fetch_req = 1'b1;
    step();
    step();
    fetch_req = 1'b0;
    check("c_req", imem_req, 1);
    check("c_addr", imem_addr, 16'h0012);
    imem_ack   = 1'b1;
    imem_rdata = 32'hF100_0002;
    step();
    imem_ack   = 1'b0;
    check("c_done", fetch_done, 1);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("c_no_req1", imem_req, 0);
    check("c_done_off", fetch_done, 0);
    step();
    check("c_no_req2", imem_req, 0);

    // Ack with no request pending is ignored.
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    step();
    imem_ack   = 1'b0;
    check("e_ir_keep", ir, 32'hF100_0002);
    check("e_no_done", fetch_done, 0);

    // Asynchronous reset in the middle of REQ; a late ack must not land.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("f_req", imem_req, 1);
    #2 rst_f = 1'b0;
    #1;
    check("f_req_clr", imem_req, 0);
    check("f_pc_clr", pc, 0);
    check("f_ir_clr", ir, 0);
    check("f_addr_clr", imem_addr, 0);
    step();
    rst_f      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    imem_ack = 1'b0;
    check("f_late_ir", ir, 0);
    check("f_late_done", fetch_done, 0);
    check("f_late_req", imem_req, 0);
`else
    // Demand fetch at 0, prefetch of 1, branch to 0x0010 (miss), prefetch 0x0011.
    do_fetch(32'h0000_0010, 0, 16'h0000, 1'b0);
    pf_ack(16'h0001, 32'h1111_0001);
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    step();
    pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    check("p_pc_10", pc, 16'h0010);
    do_fetch(32'h8123_0005, 0, 16'h0010, 1'b0);
    pf_ack(16'h0011, 32'h9000_0040);
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check("p_pc_11", pc, 16'h0011);

    // Hit: done one cycle after the request, no memory request.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("p_hit_done", fetch_done, 1);
    check("p_hit_noreq", imem_req, 0);
    check("p_hit_ir", ir, 32'h9000_0040);
    check("p_hit_busy", fetch_busy, 0);
    step();
    check("p_hit_once", fetch_done, 0);
    pf_ack(16'h0012, 32'h2222_0012);

    // Branch to 0x0040: miss, demand request to 0x0040.
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    step();
    pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    check("p_pc_40", pc, 16'h0040);
    do_fetch(32'h3333_0000, 1, 16'h0040, 1'b0);

    // Fetch while prefetch of 0x0041 is outstanding: wait, then miss to 0x0040.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("p_w_addr", imem_addr, 16'h0041);
    check("p_w_done", fetch_done, 0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h4444_0041;
    step();
    imem_ack   = 1'b0;
    check("p_w_gap", imem_req, 0);
    step();
    check("p_w_req", imem_req, 1);
    check("p_w_dem_addr", imem_addr, 16'h0040);
    check("p_w_busy", fetch_busy, 1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_0040;
    step();
    imem_ack   = 1'b0;
    check("p_w_done2", fetch_done, 1);
    check("p_w_ir", ir, 32'h5555_0040);
    step();
    pf_ack(16'h0041, 32'h6666_0041);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
